// File: rtl/tile_buffer_q_k_v_pkg.sv
// Shared types and default sizing for the Q/K/V tile ping-pong buffer.
// Fill and drain state encodings live here so the top stays compact.
package tile_buffer_q_k_v_pkg;

  localparam int DEF_NUM_FETCHES = 32;
  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_NUM_BITS    = 8;
  localparam int DEF_NUM_TILES   = 24;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_REQ,
    FILL_FILL,
    FILL_DONE
  } fill_state_e;

  typedef enum logic {
    DRN_IDLE,
    DRN_STREAM
  } drn_state_e;

endpackage

// File: rtl/tile_buffer_q_k_v_tile_bank.sv
// One tile of storage: DEPTH x WIDTH register file,
// single synchronous write port, asynchronous read port.
module tile_bank #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are don't-care after reset; no reset on storage.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tile_buffer_q_k_v.sv
// Ping-pong tile buffer between the Q/K/V BRAM fetch stage and the
// systolic array: one bank fills while the other streams out.
module tile_buffer_q_k_v
  import tile_buffer_q_k_v_pkg::*;
#(
  parameter int NUM_FETCHES_PER_TILE = DEF_NUM_FETCHES,
  parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int NUM_BITS             = DEF_NUM_BITS,
  parameter int NUM_TILES            = DEF_NUM_TILES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_start,
  output logic                  start_fetch,
  input  logic                  fetch_done,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  sa_valid,
  input  logic                  sa_ready,
  output logic [DATA_WIDTH-1:0] sa_data,
  output logic                  sa_last,
  output logic                  busy,
  output logic                  run_done,
  output logic                  err_overflow,
  output logic                  err_short
);

  localparam int PW = $clog2(NUM_FETCHES_PER_TILE);
  localparam int CW = $clog2(NUM_TILES + 1);
  localparam logic [PW-1:0] LAST_ROW  = PW'(NUM_FETCHES_PER_TILE - 1);
  localparam logic [CW-1:0] LAST_TILE = CW'(NUM_TILES - 1);

  if (DATA_WIDTH % NUM_BITS != 0) begin : g_width_chk
    $error("DATA_WIDTH must be a multiple of NUM_BITS");
  end

  fill_state_e fill_state_q, fill_state_d;
  drn_state_e  drn_state_q, drn_state_d;

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] tiles_req_q, tiles_req_d;
  logic [CW-1:0] tiles_out_q, tiles_out_d;
  logic          busy_q, busy_d;
  logic          run_done_q, run_done_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_short_q, err_short_d;

  logic          wr_en;
  logic          fill_set;
  logic          drn_clr;
  logic          run_go;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  always_comb begin
    fill_state_d = fill_state_q;
    wr_bank_d    = wr_bank_q;
    wr_ptr_d     = wr_ptr_q;
    tiles_req_d  = tiles_req_q;
    err_ovf_d    = err_ovf_q;
    err_short_d  = err_short_q;
    start_fetch  = 1'b0;
    wr_en        = 1'b0;
    fill_set     = 1'b0;
    run_go       = 1'b0;
    unique case (fill_state_q)
      FILL_IDLE: begin
        if (run_start && !busy_q) begin
          run_go       = 1'b1;
          tiles_req_d  = '0;
          err_ovf_d    = 1'b0;
          err_short_d  = 1'b0;
          fill_state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        if (!full_q[wr_bank_q]) begin
          start_fetch  = 1'b1;
          fill_state_d = FILL_FILL;
        end
      end
      FILL_FILL: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_ROW) begin
            wr_ptr_d     = '0;
            fill_state_d = FILL_DONE;
          end
        end
        // Short tile: drop what we have and ask for the same tile again.
        if (fetch_done && wr_ptr_q != '0 &&
            !(in_valid && wr_ptr_q == LAST_ROW)) begin
          err_short_d  = 1'b1;
          wr_ptr_d     = '0;
          fill_state_d = FILL_REQ;
        end
      end
      FILL_DONE: begin
        fill_set     = 1'b1;
        wr_bank_d    = ~wr_bank_q;
        tiles_req_d  = tiles_req_q + 1'b1;
        fill_state_d = (tiles_req_q == LAST_TILE) ? FILL_IDLE
                                                  : FILL_REQ;
      end
      default: fill_state_d = FILL_IDLE;
    endcase
    if (in_valid && fill_state_q != FILL_FILL) err_ovf_d = 1'b1;
  end

  always_comb begin
    drn_state_d = drn_state_q;
    rd_bank_d   = rd_bank_q;
    rd_ptr_d    = rd_ptr_q;
    tiles_out_d = tiles_out_q;
    busy_d      = busy_q;
    run_done_d  = 1'b0;
    drn_clr     = 1'b0;
    if (run_go) begin
      busy_d      = 1'b1;
      tiles_out_d = '0;
    end
    unique case (drn_state_q)
      DRN_IDLE: begin
        if (full_q[rd_bank_q]) drn_state_d = DRN_STREAM;
      end
      DRN_STREAM: begin
        if (sa_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == LAST_ROW) begin
            rd_ptr_d    = '0;
            drn_clr     = 1'b1;
            rd_bank_d   = ~rd_bank_q;
            tiles_out_d = tiles_out_q + 1'b1;
            if (tiles_out_q == LAST_TILE) begin
              run_done_d  = 1'b1;
              busy_d      = 1'b0;
              tiles_out_d = '0;
            end
            // Other bank already loaded: keep streaming with no bubble.
            if (!full_q[~rd_bank_q]) drn_state_d = DRN_IDLE;
          end
        end
      end
      default: drn_state_d = DRN_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (fill_set) full_d[wr_bank_q] = 1'b1;
    if (drn_clr)  full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state_q <= FILL_IDLE;
      drn_state_q  <= DRN_IDLE;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tiles_req_q  <= '0;
      tiles_out_q  <= '0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_short_q  <= 1'b0;
    end else begin
      fill_state_q <= fill_state_d;
      drn_state_q  <= drn_state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tiles_req_q  <= tiles_req_d;
      tiles_out_q  <= tiles_out_d;
      busy_q       <= busy_d;
      run_done_q   <= run_done_d;
      err_ovf_q    <= err_ovf_d;
      err_short_q  <= err_short_d;
    end
  end

  tile_bank #(
    .DEPTH (NUM_FETCHES_PER_TILE),
    .WIDTH (DATA_WIDTH)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_en && !wr_bank_q),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata0)
  );

  tile_bank #(
    .DEPTH (NUM_FETCHES_PER_TILE),
    .WIDTH (DATA_WIDTH)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_en && wr_bank_q),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata1)
  );

  assign sa_valid     = (drn_state_q == DRN_STREAM);
  assign sa_last      = sa_valid && (rd_ptr_q == LAST_ROW);
  assign sa_data      = !sa_valid ? '0 : (rd_bank_q ? rdata1 : rdata0);
  assign busy         = busy_q;
  assign run_done     = run_done_q;
  assign err_overflow = err_ovf_q;
  assign err_short    = err_short_q;

endmodule

// File: tb/tb_tile_buffer_q_k_v.sv
// Directed bench for the Q/K/V tile buffer: fetch-stage model,
// systolic-array sink and a queue of hand-derived row values.
module tb_tile_buffer_q_k_v;

  localparam int DW = 256;
  localparam int TW = 32;
  localparam int NT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run_start;
  logic          start_fetch;
  logic          fetch_done;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          sa_valid;
  logic          sa_ready;
  logic [DW-1:0] sa_data;
  logic          sa_last;
  logic          busy;
  logic          run_done;
  logic          err_overflow;
  logic          err_short;

  int n_tests = 0;
  int n_fail  = 0;
  int sf_cnt  = 0;
  int rd_cnt  = 0;
  int rows_got = 0;
  int sf3_rows = 0;
  bit abort = 1'b0;
  bit seen_v = 1'b0;
  time t_last_w0 = 0;
  time t_first_v = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  tile_buffer_q_k_v #(
    .NUM_FETCHES_PER_TILE (TW),
    .DATA_WIDTH           (DW),
    .NUM_BITS             (8),
    .NUM_TILES            (NT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_start    (run_start),
    .start_fetch  (start_fetch),
    .fetch_done   (fetch_done),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .sa_valid     (sa_valid),
    .sa_ready     (sa_ready),
    .sa_data      (sa_data),
    .sa_last      (sa_last),
    .busy         (busy),
    .run_done     (run_done),
    .err_overflow (err_overflow),
    .err_short    (err_short)
  );

  always @(negedge clk) begin
    if (start_fetch) sf_cnt++;
    if (run_done) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wv(input int v);
    logic [31:0] w;
    w = v;
    return {8{w}};
  endfunction

  task automatic load_exp(input int seed);
    exp_q = {};
    for (int k = 0; k < NT * TW; k++) exp_q.push_back(wv(seed + k * 2 + 2));
  endtask

  task automatic clr_cnt();
    @(posedge clk);
    #1;
    sf_cnt = 0;
    rd_cnt = 0;
    @(negedge clk);
  endtask

  task automatic pulse_run();
    @(negedge clk);
    run_start = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
  endtask

  task automatic feed(input int ntiles, input int seed,
                      input int short_tile, input int short_len);
    int t;
    int cyc;
    t = 0;
    while (t < ntiles && !abort) begin
      cyc = 0;
      while (!start_fetch && cyc < 3000 && !abort) begin
        @(negedge clk);
        cyc++;
      end
      if (abort) break;
      if (!start_fetch) begin
        chk("sf_timeout", 0, 1);
        break;
      end
      if (t == 2) sf3_rows = rows_got;
      if (t == short_tile && short_len > 0) begin
        for (int w = 0; w < short_len; w++) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_data  = wv(32'hdead0000 + w);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        fetch_done = 1'b1;
        @(negedge clk);
        fetch_done = 1'b0;
        short_len  = 0;
        continue;
      end
      for (int w = 0; w < TW && !abort; w++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = wv(seed + (t * TW + w) * 2 + 2);
        if (t == 0 && w == TW - 1) t_last_w0 = $time;
      end
      if (abort) break;
      @(negedge clk);
      in_valid   = 1'b0;
      fetch_done = 1'b1;
      @(negedge clk);
      fetch_done = 1'b0;
      t++;
    end
    in_valid   = 1'b0;
    fetch_done = 1'b0;
  endtask

  task automatic sink(input int nrows, input int mode);
    int cyc;
    bit stalled;
    cyc = 0;
    stalled = 1'b0;
    rows_got = 0;
    while (rows_got < nrows && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) sa_ready = cyc[0];
      else if (mode == 2) sa_ready = (cyc > 200);
      else sa_ready = 1'b1;
      if (mode == 2 && cyc == 200) chk("sf_held", sf_cnt, 2);
      if (stalled) chk("hold_valid", sa_valid, 1);
      stalled = sa_valid && !sa_ready;
      if (stalled && exp_q.size() > 0) chk("stall_data", sa_data, exp_q[0]);
      if (sa_valid && !seen_v) begin
        seen_v = 1'b1;
        t_first_v = $time;
      end
      if (sa_valid && sa_ready) begin
        if (exp_q.size() == 0) chk("extra_row", 1, 0);
        else chk("row", sa_data, exp_q.pop_front());
        chk("last", sa_last, (rows_got % TW) == TW - 1);
        rows_got++;
      end
    end
    if (rows_got < nrows) chk("sink_timeout", rows_got, nrows);
  endtask

  task automatic full_run(input int seed, input int mode,
                          input int short_tile, input int short_len);
    load_exp(seed);
    clr_cnt();
    seen_v = 1'b0;
    pulse_run();
    chk("busy_on", busy, 1);
    fork
      feed(NT, seed, short_tile, short_len);
      sink(NT * TW, mode);
    join
    repeat (4) @(negedge clk);
    chk("run_done_cnt", rd_cnt, 1);
    chk("busy_off", busy, 0);
    chk("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    run_start  = 1'b0;
    fetch_done = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    sa_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sf", start_fetch, 0);
    chk("rst_valid", sa_valid, 0);
    chk("rst_data", sa_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_overflow, err_short, run_done, sa_last}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic run, always ready, rows 2,4,...
    full_run(0, 0, -1, 0);
    chk("t1_sf", sf_cnt, NT);
    chk("t1_latency", t_first_v - t_last_w0, 30);
    chk("t1_errs", {err_overflow, err_short}, 0);

    // ready toggling every cycle
    full_run(1000, 1, -1, 0);
    chk("t2_sf", sf_cnt, NT);

    // long stall: third fetch waits for first drain
    full_run(5000, 2, -1, 0);
    chk("t3_sf", sf_cnt, NT);
    chk("t3_sf3_after_drain", sf3_rows >= TW, 1);

    // short tile 1 after 20 words
    full_run(9000, 0, 1, 20);
    chk("t4_err_short", err_short, 1);
    chk("t4_sf", sf_cnt, NT + 1);
    chk("t4_ovf", err_overflow, 0);

    // stray in_valid while idle
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = wv(32'h0bad);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_valid", sa_valid, 0);
    end
    chk("t5_ovf", err_overflow, 1);
    chk("t5_short_sticky", err_short, 1);

    // reset mid-stream at row 10 of tile 1
    load_exp(20000);
    clr_cnt();
    pulse_run();
    chk("t6_errs_clr", {err_overflow, err_short}, 0);
    abort = 1'b0;
    fork
      feed(NT, 20000, -1, 0);
      begin
        sink(TW + 10, 0);
        abort = 1'b1;
      end
    join
    chk("t6_pre_valid", sa_valid, 1);
    chk("t6_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", sa_valid, 0);
    chk("t6_rst_data", sa_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_misc", {start_fetch, sa_last, run_done}, 0);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_run_done", rd_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    full_run(30000, 0, -1, 0);
    chk("t6_sf", sf_cnt, NT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
